// File: rtl/decoder_rr_sched_pkg.sv
// Shared types and helpers for the round-robin decoder scheduler.
package decoder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } sched_state_t;

    // Widest select code the shared decoder helper supports.
    localparam int MAX_SEL_W = 6;

    function automatic int owner_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

    function automatic logic [2**MAX_SEL_W-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] sel);
        logic [2**MAX_SEL_W-1:0] dec;
        dec      = '0;
        dec[sel] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/decoder_rr_sched_if.sv
// Requester / consumer handshake bundle of the decoder scheduler.
interface decoder_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 3
) ();
    import decoder_sched_pkg::*;

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*SEL_W-1:0]         req_sel;
    logic [NUM_REQ-1:0]               req_ready;
    logic [2**SEL_W-1:0]              dec_out;
    logic                             dec_valid;
    logic [owner_width(NUM_REQ)-1:0]  dec_owner;
    logic                             dec_ready;

    modport master (
        output req_valid, req_sel, dec_ready,
        input  req_ready, dec_out, dec_valid, dec_owner
    );

    modport slave (
        input  req_valid, req_sel, dec_ready,
        output req_ready, dec_out, dec_valid, dec_owner
    );

endinterface

// File: rtl/decoder_rr_sched_arbiter.sv
// Combinational round-robin arbiter: the requester nearest after last_grant wins.
module rr_arbiter
    import decoder_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWN_W-1:0]   grant_idx,
    output logic               grant_any
);

    int         dist_s;
    int         best_s;
    logic       take_s;
    logic [OWN_W-1:0] idx_s;

    // Pick the asserted request with the smallest rotated distance from last_grant+1.
    always_comb begin
        dist_s = 0;
        best_s = NUM_REQ;
        take_s = 1'b0;
        idx_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            take_s = req[i] && (dist_s < best_s);
            best_s = take_s ? dist_s : best_s;
            idx_s  = take_s ? OWN_W'(i) : idx_s;
        end
    end

    assign grant_any = (best_s < NUM_REQ);
    assign grant_idx = idx_s;
    assign grant     = grant_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_s) : {NUM_REQ{1'b0}};

endmodule

// File: rtl/decoder_rr_sched.sv
// Shares one registered select decoder among NUM_REQ requesters in round-robin order,
// holding each strobe for HOLD_CYCLES cycles and until the consumer acknowledges it.
module decoder_rr_sched
    import decoder_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    decoder_rr_sched_if.slave bus
);

    localparam int OWN_W = owner_width(NUM_REQ);
    localparam int DEC_W = 2**SEL_W;
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    sched_state_t        state_r;
    sched_state_t        state_n_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_n_s;
    logic [DEC_W-1:0]    dec_out_r;
    logic                dec_valid_r;
    logic [OWN_W-1:0]    owner_r;
    logic [OWN_W-1:0]    last_grant_r;

    logic [NUM_REQ-1:0]  grant_s;
    logic [OWN_W-1:0]    grant_idx_s;
    logic                grant_any_s;
    logic                completion_s;
    logic                load_s;
    logic                accept_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic [SEL_W-1:0]    sel_s;
    logic [DEC_W-1:0]    dec_next_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .grant_any  (grant_any_s)
    );

    // dec_ready only counts once the minimum hold has been served.
    assign completion_s = bus.dec_ready &&
                          ((state_r == WAIT) || ((state_r == HOLD) && (cnt_r == 4'd1)));
    assign load_s   = (state_r == IDLE) || completion_s;
    assign accept_s = load_s && grant_any_s;

    // Accept is gated off while reset is held so nothing looks accepted during reset.
    always_comb begin
        ready_s = '0;
        if (rst) begin
            ready_s = '0;
        end else if (load_s) begin
            ready_s = grant_s;
        end else begin
            ready_s = '0;
        end
    end

    // Select code of the granted requester (grant is one-hot, so OR-folding is exact).
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_s = sel_s | (grant_s[i] ? bus.req_sel[i*SEL_W +: SEL_W] : {SEL_W{1'b0}});
        end
    end

    assign dec_next_s = DEC_W'(onehot_dec(MAX_SEL_W'(sel_s)));

    // Next-state and hold-counter logic.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        if (accept_s) begin
            state_n_s = (HOLD_CYCLES == 1) ? WAIT : HOLD;
            cnt_n_s   = HOLD_INIT;
        end else if (completion_s) begin
            state_n_s = IDLE;
            cnt_n_s   = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = IDLE;
                    cnt_n_s   = 4'd0;
                end
                HOLD: begin
                    cnt_n_s   = cnt_r - 4'd1;
                    state_n_s = (cnt_r <= 4'd1) ? WAIT : HOLD;
                end
                WAIT: begin
                    state_n_s = WAIT;
                    cnt_n_s   = 4'd0;
                end
                default: begin
                    state_n_s = IDLE;
                    cnt_n_s   = 4'd0;
                end
            endcase
        end
    end

    // State and hold-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Output strobe registers; reset starts the pointer so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_out_r    <= '0;
            dec_valid_r  <= 1'b0;
            owner_r      <= '0;
            last_grant_r <= OWN_W'(NUM_REQ - 1);
        end else if (accept_s) begin
            dec_out_r    <= dec_next_s;
            dec_valid_r  <= 1'b1;
            owner_r      <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else if (completion_s) begin
            dec_out_r    <= '0;
            dec_valid_r  <= 1'b0;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.dec_out   = dec_out_r;
    assign bus.dec_valid = dec_valid_r;
    assign bus.dec_owner = owner_r;

endmodule

// File: doc/decoder_rr_sched.md
# decoder_rr_sched

Round-robin scheduler that shares one registered N-to-2^N decoder between `NUM_REQ` requesters. Each requester presents a select code with a valid/ready handshake. The block grants one requester at a time and registers the decoded one-hot strobe. It holds the strobe for at least `HOLD_CYCLES` cycles and until the downstream consumer acknowledges it. It sits between the requesters and the decoder-driven resource, and is verified with the same in/out agent split as the decoder bench.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `SEL_W`, 3: select code width; decoder output is 2^SEL_W bits.
- `HOLD_CYCLES`, 2: minimum cycles the strobe stays asserted, 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_sel`  in  NUM_REQ*SEL_W  packed select codes; requester i uses bits [i*SEL_W +: SEL_W].
- `req_ready`  out  NUM_REQ  one-hot accept; combinational.
- `dec_out`  out  2^SEL_W  registered one-hot decoded strobe.
- `dec_valid`  out  1  strobe is active.
- `dec_owner`  out  clog2(NUM_REQ)  index of the requester that owns the strobe.
- `dec_ready`  in  1  consumer acknowledge.

## Operation
- States:
  - IDLE: no strobe.
  - HOLD: strobe active, hold counter > 0.
  - WAIT: hold satisfied, waiting for `dec_ready`.
- `load` = (state==IDLE) or completion.
- Completion = state==WAIT and `dec_ready`; also state==HOLD, counter==1 and `dec_ready`.
- Arbitration:
  - Combinational round-robin among asserted `req_valid`.
  - Search starts at (last_grant+1) mod NUM_REQ.
  - `req_ready[i]` = grant[i] and `load`.
  - At most one bit of `req_ready` is set.
- Accept (req_valid[i] and req_ready[i] at an edge):
  - `dec_out` <= 1 << req_sel[i].
  - `dec_owner` <= i; last_grant <= i.
  - Hold counter <= HOLD_CYCLES.
  - Next state HOLD, or WAIT when HOLD_CYCLES==1.
- HOLD: counter decrements each cycle; on reaching 1 the next state is WAIT. `dec_ready` is ignored until the final hold cycle.
- Completion:
  - If another request is granted that cycle, reload directly (back-to-back, no bubble).
  - Otherwise go to IDLE and clear `dec_out` and `dec_valid`.
- Requesters hold `req_valid` and `req_sel` stable until accepted; the block does not check this.
- An unaccepted `req_valid` may drop without effect.

## Timing
- Reset values:
  - `dec_out`=0, `dec_valid`=0, `dec_owner`=0.
  - State IDLE, counter 0.
  - last_grant = NUM_REQ-1, so requester 0 has highest priority after reset.
  - `req_ready` = 0 while `rst` is high.
- Latency: accept at edge N; `dec_valid` and `dec_out` are valid after edge N and stay valid for at least HOLD_CYCLES cycles.
- Throughput: one transfer per HOLD_CYCLES cycles when `dec_ready` is held high.
- Simultaneous events:
  - Completion plus pending requests: the next owner is chosen in the same cycle from the updated pointer.
  - A single repeated requester can win consecutively when it is the only one valid.
- Reset mid-operation: the strobe drops immediately (asynchronously). The in-flight request is lost, and requesters must re-present it.
- `dec_ready` high in IDLE is ignored.

## Structure
- Package `decoder_sched_pkg`:
  - State enum `sched_state_t` (IDLE, HOLD, WAIT).
  - Localparam helper for owner width.
  - Function `onehot_dec(sel)`.
- Sub-module `rr_arbiter`: combinational round-robin with inputs req and last_grant, and outputs grant one-hot and grant index.
- The top holds the FSM, the hold counter, and the output registers.

## Test plan
- Single request, NUM_REQ=4, SEL_W=3, HOLD=2:
  - Stimulus: req_valid=4'b0010, sel1=5, `dec_ready` high.
  - Required: req_ready=4'b0010 for one cycle; then `dec_out`=8'h20, `dec_owner`=1, `dec_valid` for exactly 2 cycles; then IDLE.
- Fairness:
  - Stimulus: all four requesters valid continuously, `dec_ready` high.
  - Required: owners 0,1,2,3,0… with each strobe lasting 2 cycles and no bubbles.
- Backpressure:
  - Stimulus: `dec_ready` low for 5 cycles after accept.
  - Required: `dec_valid` held for 6 cycles; `dec_out` stable; no `req_ready` asserted meanwhile.
- Pointer wrap:
  - Stimulus: after owner 3, only requesters 0 and 2 are valid.
  - Required: requester 0 is granted next, then requester 2.
- Reset mid-HOLD:
  - Stimulus: `rst` asserted during the first hold cycle.
  - Required: `dec_out`=0 and `dec_valid`=0 without waiting for a clock edge. After release, requester 0 wins over a simultaneous requester 3.
- HOLD_CYCLES=1 corner:
  - Stimulus: back-to-back requests on 0 and 1, sel=0 and sel=7.
  - Required: `dec_out` 8'h01 then 8'h80 on consecutive cycles.
